// File: rtl/spi_host_mode0.sv
// SPI mode 0 controller (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// sclk/cs_n/mosi are divided down from clk; cs_n is held low across a burst until a byte marked last.
module spi_host_mode0 #(
  parameter int unsigned DIV_HALF = 4,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LAST = 8'(DIV_HALF - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t     r_state;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic       r_last;
  logic       r_sclk;
  logic       r_cs_n;
  logic       r_mosi;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_busy;
  logic       r_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_last     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        // tx_ready is high in both of these states, so tx_valid alone is an accept
        ST_IDLE, ST_WAIT: begin
          if (tx_valid) begin
            r_tx_shift <= tx_data;
            r_last     <= tx_last;
            r_cs_n     <= 1'b0;
            r_mosi     <= tx_data[7];
            r_bit      <= '0;
            r_div      <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_sclk     <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], miso};
            r_state    <= ST_HIGH;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        ST_HIGH: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            if (r_bit == 3'd7) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              if (r_last) begin
                r_state <= ST_HOLD;
              end else begin
                r_state    <= ST_WAIT;
                r_tx_ready <= 1'b1;
              end
            end else begin
              r_mosi     <= r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              r_bit      <= r_bit + 3'd1;
              r_state    <= ST_LOW;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        ST_HOLD: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= ST_GAP;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        ST_GAP: begin
          if (r_div == GAP_LAST) begin
            r_div      <= '0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign sclk     = r_sclk;
  assign cs_n     = r_cs_n;
  assign mosi     = r_mosi;

endmodule
